// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and memory-access stages.
// Data requests win ties; stale fetches after a branch flush are dropped.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                busy
);

  // state | meaning
  // IDLE  | sample requests, latch the winner
  // ISSUE | one-cycle memory strobe
  // WAIT  | count down read latency, capture data on terminal count
  // RESP  | one-cycle ready pulse to the granted requester
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int STRB_W = DATA_W / 8;

  state_t              state;
  logic [2:0]          cnt;
  logic                gnt_dm;
  logic                discard;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt_dm  <= 1'b0;
      discard <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (dm_req) begin
            gnt_dm  <= 1'b1;
            we_q    <= dm_we;
            addr_q  <= dm_addr;
            wdata_q <= dm_we ? dm_wdata : '0;
            wstrb_q <= dm_we ? dm_wstrb : '0;
            state   <= ISSUE;
          end else if (if_req && !if_flush) begin
            gnt_dm  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= '0;
            wstrb_q <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!gnt_dm && if_flush) discard <= 1'b1;
          if (we_q) begin
            state <= RESP;
          end else begin
            cnt   <= LATENCY[2:0];
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!gnt_dm && if_flush) discard <= 1'b1;
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rdata_q <= mem_rdata;
            state   <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign mem_en    = (state == ISSUE);
  assign mem_we    = (state == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  // A flushed fetch still finishes its memory cycle but never signals ready.
  assign if_ready  = (state == RESP) && !gnt_dm && !discard;
  assign dm_ready  = (state == RESP) && gnt_dm;
  assign if_rdata  = if_ready ? rdata_q : '0;
  assign dm_rdata  = (dm_ready && !we_q) ? rdata_q : '0;

  assign stall_if  = reset && if_req && !if_ready && !if_flush;
  assign stall_mem = reset && dm_req && !dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=2 instance plus a LATENCY=1
// instance exercised with alternating load/fetch pairs.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;

  logic        if_req, if_flush, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem, busy;

  logic        b_if_req, b_if_flush, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
  logic [3:0]  b_dm_wstrb;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wstrb;
  logic        b_if_ready, b_dm_ready, b_mem_en, b_mem_we, b_stall_if, b_stall_mem, b_busy;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_flush(b_if_flush),
    .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_wstrb(b_dm_wstrb), .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata),
    .stall_if(b_stall_if), .stall_mem(b_stall_mem), .busy(b_busy)
  );

  // Memory model for the LATENCY=1 instance: data is a fixed function of address.
  assign b_mem_rdata = b_mem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    mem_rdata = '0;
    b_if_req = 0; b_if_flush = 0; b_if_addr = '0;
    b_dm_req = 0; b_dm_we = 0; b_dm_addr = '0; b_dm_wdata = '0; b_dm_wstrb = '0;
    #2;
    reset = 1'b0;
    if_req = 1'b1;

    // reset: every output low, stall gated even with a request present
    smp();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_stall_if", stall_if, 0);
    chk("rst_if_rdata", if_rdata, 0);
    cyc();
    reset = 1'b1;
    if_req = 1'b0;
    cyc();

    // lone fetch, LATENCY=2
    if_req = 1; if_addr = 32'h100; mem_rdata = 32'hBAD0BAD0;
    smp();
    chk("f1_t0_stall", stall_if, 1);
    chk("f1_t0_mem_en", mem_en, 0);
    chk("f1_t0_busy", busy, 0);
    cyc();
    smp();
    chk("f1_t1_mem_en", mem_en, 1);
    chk("f1_t1_mem_we", mem_we, 0);
    chk("f1_t1_addr", mem_addr, 32'h100);
    chk("f1_t1_wstrb", mem_wstrb, 0);
    chk("f1_t1_stall", stall_if, 1);
    cyc();
    smp();
    chk("f1_t2_mem_en", mem_en, 0);
    chk("f1_t2_ready", if_ready, 0);
    cyc();
    mem_rdata = 32'h00500093;
    smp();
    chk("f1_t3_ready", if_ready, 0);
    chk("f1_t3_stall", stall_if, 1);
    cyc();
    mem_rdata = 32'hBAD0BAD0;
    smp();
    chk("f1_t4_ready", if_ready, 1);
    chk("f1_t4_rdata", if_rdata, 32'h00500093);
    chk("f1_t4_stall", stall_if, 0);
    cyc();
    if_req = 0;
    smp();
    chk("f1_t5_ready", if_ready, 0);
    chk("f1_t5_rdata", if_rdata, 0);
    chk("f1_t5_busy", busy, 0);

    // simultaneous load and fetch: data wins
    cyc();
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    if_req = 1; if_addr = 32'h104; mem_rdata = 32'h0;
    smp();
    chk("sim_t0_stall_mem", stall_mem, 1);
    chk("sim_t0_stall_if", stall_if, 1);
    cyc();
    smp();
    chk("sim_t1_addr", mem_addr, 32'h2000);
    chk("sim_t1_mem_en", mem_en, 1);
    cyc();
    cyc();
    mem_rdata = 32'hDEADBEEF;
    cyc();
    mem_rdata = 32'h0;
    smp();
    chk("sim_t4_dm_ready", dm_ready, 1);
    chk("sim_t4_dm_rdata", dm_rdata, 32'hDEADBEEF);
    chk("sim_t4_if_ready", if_ready, 0);
    chk("sim_t4_stall_if", stall_if, 1);
    chk("sim_t4_stall_mem", stall_mem, 0);
    cyc();
    dm_req = 0;
    smp();
    chk("sim_t5_busy", busy, 0);
    chk("sim_t5_stall_if", stall_if, 1);
    chk("sim_t5_dm_rdata", dm_rdata, 0);
    cyc();
    smp();
    chk("sim_t6_mem_en", mem_en, 1);
    chk("sim_t6_addr", mem_addr, 32'h104);
    cyc();
    cyc();
    mem_rdata = 32'h11112222;
    smp();
    chk("sim_t8_if_ready", if_ready, 0);
    cyc();
    mem_rdata = 32'h0;
    smp();
    chk("sim_t9_if_ready", if_ready, 1);
    chk("sim_t9_if_rdata", if_rdata, 32'h11112222);
    cyc();
    if_req = 0;

    // store
    dm_req = 1; dm_we = 1; dm_addr = 32'h2004; dm_wdata = 32'h12345678; dm_wstrb = 4'b0011;
    smp();
    chk("st_t0_stall_mem", stall_mem, 1);
    cyc();
    smp();
    chk("st_t1_mem_en", mem_en, 1);
    chk("st_t1_mem_we", mem_we, 1);
    chk("st_t1_wstrb", mem_wstrb, 4'b0011);
    chk("st_t1_wdata", mem_wdata, 32'h12345678);
    chk("st_t1_addr", mem_addr, 32'h2004);
    chk("st_t1_ready", dm_ready, 0);
    cyc();
    smp();
    chk("st_t2_ready", dm_ready, 1);
    chk("st_t2_mem_we", mem_we, 0);
    chk("st_t2_stall_mem", stall_mem, 0);
    cyc();
    dm_req = 0; dm_we = 0; dm_wdata = '0; dm_wstrb = '0;
    smp();
    chk("st_t3_busy", busy, 0);
    chk("st_t3_ready", dm_ready, 0);

    // fetch flushed during WAIT, then a fresh fetch to 0x200
    cyc();
    if_req = 1; if_addr = 32'h180; mem_rdata = 32'h0;
    cyc();
    smp();
    chk("fl_t1_mem_en", mem_en, 1);
    cyc();
    if_flush = 1;
    smp();
    chk("fl_t2_stall_if", stall_if, 0);
    cyc();
    if_flush = 0; if_req = 0; mem_rdata = 32'h0BADF00D;
    smp();
    chk("fl_t3_busy", busy, 1);
    cyc();
    mem_rdata = 32'h0;
    smp();
    chk("fl_t4_if_ready", if_ready, 0);
    chk("fl_t4_if_rdata", if_rdata, 0);
    chk("fl_t4_busy", busy, 1);
    cyc();
    if_req = 1; if_addr = 32'h200;
    smp();
    chk("fl_t5_busy", busy, 0);
    cyc();
    smp();
    chk("fl2_t1_addr", mem_addr, 32'h200);
    chk("fl2_t1_mem_en", mem_en, 1);
    cyc();
    cyc();
    mem_rdata = 32'h00A00113;
    cyc();
    mem_rdata = 32'h0;
    smp();
    chk("fl2_t4_ready", if_ready, 1);
    chk("fl2_t4_rdata", if_rdata, 32'h00A00113);
    cyc();
    if_req = 0;

    // flush in IDLE blocks the fetch grant
    if_req = 1; if_addr = 32'h240; if_flush = 1;
    smp();
    chk("fi_stall_if", stall_if, 0);
    cyc();
    if_req = 0; if_flush = 0;
    smp();
    chk("fi_busy", busy, 0);
    chk("fi_mem_en", mem_en, 0);

    // reset asserted during WAIT
    cyc();
    if_req = 1; if_addr = 32'h300;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rw_busy", busy, 0);
    chk("rw_mem_addr", mem_addr, 0);
    chk("rw_stall_if", stall_if, 0);
    chk("rw_if_ready", if_ready, 0);
    cyc();
    smp();
    chk("rw_held_ready", if_ready, 0);
    chk("rw_held_mem_en", mem_en, 0);
    cyc();
    reset = 1'b1; if_addr = 32'h304;
    smp();
    chk("rw_t0_stall_if", stall_if, 1);
    chk("rw_t0_busy", busy, 0);
    cyc();
    smp();
    chk("rw_t1_mem_en", mem_en, 1);
    chk("rw_t1_addr", mem_addr, 32'h304);
    cyc();
    cyc();
    mem_rdata = 32'h7777AAAA;
    smp();
    chk("rw_t3_ready", if_ready, 0);
    cyc();
    mem_rdata = 32'h0;
    smp();
    chk("rw_t4_ready", if_ready, 1);
    chk("rw_t4_rdata", if_rdata, 32'h7777AAAA);
    cyc();
    if_req = 0;
    cyc();

    // LATENCY=1: ten load/fetch pairs raised together
    for (int i = 0; i < 10; i++) begin
      int dm_n, if_n, dm_at, if_at;
      logic [31:0] dm_a, if_a;
      dm_a = 32'h3000 + 32'(4 * i);
      if_a = 32'h0400 + 32'(4 * i);
      b_dm_req = 1; b_dm_addr = dm_a;
      b_if_req = 1; b_if_addr = if_a;
      dm_n = 0; if_n = 0; dm_at = -1; if_at = -1;
      for (int c = 0; c < 10; c++) begin
        smp();
        if (c == 0) chk("l1_stall_mem", b_stall_mem, 1);
        if (c == 1) begin
          chk("l1_mem_en", b_mem_en, 1);
          chk("l1_mem_we", b_mem_we, 0);
          chk("l1_mem_wstrb", b_mem_wstrb, 0);
          chk("l1_mem_wdata", b_mem_wdata, 0);
        end
        if (b_dm_ready) begin
          dm_n++; dm_at = c;
          chk("l1_dm_rdata", b_dm_rdata, dm_a ^ 32'hA5A5_0000);
        end
        if (b_if_ready) begin
          if_n++; if_at = c;
          chk("l1_if_rdata", b_if_rdata, if_a ^ 32'hA5A5_0000);
        end
        cyc();
        if (dm_n > 0) b_dm_req = 0;
        if (if_n > 0) b_if_req = 0;
      end
      chk("l1_dm_count", 32'(dm_n), 1);
      chk("l1_if_count", 32'(if_n), 1);
      chk("l1_dm_cycle", 32'(dm_at), 3);
      chk("l1_if_cycle", 32'(if_at), 7);
      chk("l1_idle", b_busy, 0);
      chk("l1_stall_if", b_stall_if, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data memory between the fetch stage and the memory-access stage of the five-stage pipeline. It grants one requester at a time, sequences each memory access through a fixed-latency handshake, and returns data with a one-cycle ready pulse. While a requester waits, it drives per-stage stall requests into hazard control. It also discards fetch results that a branch flush has made stale.

## Interface
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- LATENCY, 2, memory read latency in cycles from the issue cycle; legal range 1..7
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; one clock
- if_req  input  1  fetch read request; held until if_ready, or until dropped by flush
- if_addr  input  ADDR_W  fetch address; stable while if_req is high
- if_flush  input  1  branch flush of the fetch stage (connected to flushE)
- if_rdata  output  DATA_W  fetched instruction; valid only while if_ready is high
- if_ready  output  1  one-cycle completion pulse for fetch
- dm_req  input  1  data request; held until dm_ready
- dm_we  input  1  1 = write, 0 = read
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  write data
- dm_wstrb  input  DATA_W/8  byte-enable strobes
- dm_rdata  output  DATA_W  load data; valid only while dm_ready is high
- dm_ready  output  1  one-cycle completion pulse for data
- mem_en, mem_we  output  1 each  memory strobes; high only in ISSUE
- mem_addr, mem_wdata  output  ADDR_W, DATA_W  driven from the latched request
- mem_wstrb  output  DATA_W/8  zero for reads
- mem_rdata  input  DATA_W  memory read data
- stall_if  output  1  if_req & ~if_ready & ~if_flush
- stall_mem  output  1  dm_req & ~dm_ready
- busy  output  1  state != IDLE

## Operation
- FSM states:
  - IDLE: samples requests at the clock edge. dm_req has priority over if_req because the memory-stage instruction is older. The winning request's address, data, strobes, we and grant are latched, and the state moves to ISSUE.
  - ISSUE: asserts mem_en (and mem_we for writes) for exactly one cycle. A write goes to RESP; a read goes to WAIT with cnt = LATENCY.
  - WAIT: decrements cnt each cycle. On the cycle where cnt == 1, mem_rdata is captured into the read register and the state moves to RESP.
  - RESP: pulses the granted requester's ready for one cycle (dm_ready for a write or load; if_ready for a fetch), then returns to IDLE.
- Flush:
  - A fetch grant carries a discard flag, set when if_flush is high in any cycle from the IDLE edge that granted the fetch through WAIT.
  - A discarded fetch still completes its memory cycle, but RESP drives no if_ready. if_rdata/dm_rdata output ports are zero outside ready.
  - if_flush in IDLE with if_req high: the fetch is not granted that edge.
- The ready pulse is combinational off the RESP state and the grant. The requester updates req/addr at the next edge; IDLE samples those new values.
- Both requests high in IDLE → data is granted; fetch stays stalled and is granted on the next IDLE if still pending.
- Reset asserted at any time: state=IDLE, cnt=0, grant and discard flags cleared, all outputs 0. Any in-flight memory transaction is abandoned.

## Timing
- Reset values: every output is 0.
- Read (fetch or load) issued from IDLE at cycle t0:
  - ISSUE at t0+1
  - WAIT for t0+2 .. t0+LATENCY+1
  - ready at t0+LATENCY+2
- Write issued from IDLE at t0: ISSUE at t0+1, dm_ready at t0+2.
- Back-to-back throughput: the next IDLE follows RESP. A read occupies LATENCY+3 cycles; a write occupies 3 cycles.
- stall_if and stall_mem are combinational. Each is high from req assertion through the cycle before ready, and low in the ready cycle.

## Test plan
- Lone fetch, LATENCY=2, if_addr=0x100, mem_rdata=0x00500093 at cycle t0+3:
  - mem_en high only at t0+1
  - if_ready at t0+4 with if_rdata=0x00500093
  - stall_if high t0..t0+3
- Simultaneous dm_req (load 0x2000→0xDEADBEEF) and if_req (0x104):
  - dm_ready with 0xDEADBEEF at t0+4
  - fetch ISSUE at t0+6, if_ready at t0+9
- Store dm_addr=0x2004, dm_wdata=0x12345678, dm_wstrb=4'b0011:
  - mem_we=1, mem_wstrb=0011 at t0+1
  - dm_ready at t0+2
- Fetch granted, then if_flush pulsed in WAIT:
  - no if_ready; busy drops after RESP
  - a new fetch to 0x200 in the following IDLE completes normally
- reset low during WAIT:
  - all outputs 0 immediately; no ready pulse
  - after release, a fresh fetch completes with LATENCY+2 latency
- LATENCY=1 build: read ready at t0+3; 10 alternating load/fetch pairs with no ready lost or duplicated.
